// File: rtl/iter_muldiv_if.sv
// Handshake and result bundle between the execute stage and the iterative mul/div unit.
`default_nettype none

interface iter_muldiv_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, stall, done, hi, lo
  );
endinterface

`default_nettype wire

// File: rtl/iter_muldiv.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit producing a HI/LO pair, with
// execute-stage stall generation and a synchronous cancel for exception flushes.
`default_nettype none

module iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  iter_muldiv_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic               bzero_q, bzero_d;
  logic               sgn_a_q, sgn_a_d;
  logic               sgn_b_q, sgn_b_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               in_signed;
  logic [WIDTH-1:0]   in_mag_a;
  logic [WIDTH-1:0]   in_mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic               neg_result;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Signed ops run on magnitudes; the most negative value maps onto itself,
  // which is already its correct unsigned magnitude.
  assign in_signed = ~bus.op[0];
  assign in_mag_a  = (in_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign in_mag_b  = (in_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide: acc = {partial remainder, dividend/quotient bits}.
  assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, mag_b_q};
  assign div_next  = div_diff[WIDTH]
                   ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                   : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

  assign neg_result = ~op_q[0] & (sgn_a_q ^ sgn_b_q);
  assign prod_fix   = neg_result ? -acc_q : acc_q;
  assign quo_fix    = neg_result ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix    = (~op_q[0] & sgn_a_q) ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    bzero_d = bzero_q;
    sgn_a_d = sgn_a_q;
    sgn_b_d = sgn_b_q;
    mag_b_d = mag_b_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !done_q) begin
          op_d    = bus.op;
          a_d     = bus.a;
          bzero_d = (bus.b == '0);
          sgn_a_d = in_signed & bus.a[WIDTH-1];
          sgn_b_d = in_signed & bus.b[WIDTH-1];
          mag_b_d = in_mag_b;
          acc_d   = {{WIDTH{1'b0}}, in_mag_a};
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = op_q[1] ? div_next : mul_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = S_FIXUP;
        end
      end
      S_FIXUP: begin
        if (!op_q[1]) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (bzero_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A flush wins over everything, including a same-cycle start or result write.
    if (bus.cancel) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  assign busy_d = (state_d != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      bzero_q <= 1'b0;
      sgn_a_q <= 1'b0;
      sgn_b_q <= 1'b0;
      mag_b_q <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      bzero_q <= bzero_d;
      sgn_a_q <= sgn_a_d;
      sgn_b_q <= sgn_b_d;
      mag_b_q <= mag_b_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.stall = (bus.start & ~done_q & (state_q == S_IDLE)) | busy_q;

endmodule

`default_nettype wire

// File: tb/tb_iter_muldiv.sv
// Scoreboard bench for iter_muldiv at WIDTH=32 and WIDTH=8 against an arithmetic reference model.
`default_nettype none

module tb_iter_muldiv;

  localparam int W  = 32;
  localparam int WN = 8;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic clk    = 1'b0;
  logic rst_w  = 1'b0;
  logic rst_n8 = 1'b0;

  always #5 clk = ~clk;

  iter_muldiv_if #(.WIDTH(W))  bw();
  iter_muldiv_if #(.WIDTH(WN)) bn();

  iter_muldiv #(.WIDTH(W))  dut_w (.clk(clk), .rst(rst_w),  .bus(bw));
  iter_muldiv #(.WIDTH(WN)) dut_n (.clk(clk), .rst(rst_n8), .bus(bn));

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_w[$];
  logic [63:0] exp_n[$];
  logic [63:0] mon_e_w;
  logic [63:0] mon_e_n;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Returns {hi, lo} in the low WIDTH bits of each 32-bit half.
  function automatic logic [63:0] model(input int w, input logic [1:0] op,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [63:0] mask, p, hi, lo;
    longint sa, sb;
    mask = (w == 32) ? 64'h0000_0000_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    p = '0;
    hi = '0;
    lo = '0;
    case (op)
      OP_MULT: begin
        p  = 64'(sa * sb);
        hi = (p >> w) & mask;
        lo = p & mask;
      end
      OP_MULTU: begin
        p  = {32'd0, a} * {32'd0, b};
        hi = (p >> w) & mask;
        lo = p & mask;
      end
      default: begin
        if (b == 32'd0) begin
          lo = mask;
          hi = {32'd0, a};
        end else if (op == OP_DIV) begin
          lo = 64'(sa / sb) & mask;
          hi = 64'(sa % sb) & mask;
        end else begin
          lo = {32'd0, a / b};
          hi = {32'd0, a % b};
        end
      end
    endcase
    return {hi[31:0], lo[31:0]};
  endfunction

  always @(negedge clk) begin
    if (bw.done === 1'b1) begin
      if (exp_w.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL w32_unexpected_done: got done=1 hi=%h lo=%h, expected no done", bw.hi, bw.lo);
      end else begin
        mon_e_w = exp_w.pop_front();
        check("w32_result", {bw.hi, bw.lo}, mon_e_w);
      end
    end
    if (bn.done === 1'b1) begin
      if (exp_n.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL w8_unexpected_done: got done=1 hi=%h lo=%h, expected no done", bn.hi, bn.lo);
      end else begin
        mon_e_n = exp_n.pop_front();
        check("w8_result", {24'd0, bn.hi, 24'd0, bn.lo}, mon_e_n);
      end
    end
  end

  // Called at a negedge with the unit idle; start is held until the cycle after done.
  task automatic run_w(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int cyc;
    logic stall_ok;
    bw.op = op;
    bw.a = a;
    bw.b = b;
    bw.start = 1'b1;
    exp_w.push_back(model(W, op, a, b));
    #1;
    stall_ok = (bw.stall === 1'b1);
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        bw.a = $urandom;
        bw.b = $urandom;
        bw.op = 2'($urandom_range(0, 3));
      end
      if (bw.done === 1'b1) break;
      if (bw.stall !== 1'b1 || bw.busy !== 1'b1) stall_ok = 1'b0;
    end
    check("w32_latency", 64'(cyc), 64'(W + 2));
    check("w32_stall_while_busy", {63'd0, stall_ok}, 64'd1);
    check("w32_stall_done_cycle", {62'd0, bw.stall, bw.busy}, 64'd0);
    @(negedge clk);
    check("w32_no_retrigger", {63'd0, bw.busy}, 64'd0);
    bw.start = 1'b0;
  endtask

  task automatic run_n(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int cyc;
    bn.op = op;
    bn.a = a;
    bn.b = b;
    bn.start = 1'b1;
    exp_n.push_back(model(WN, op, {24'd0, a}, {24'd0, b}));
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bn.done === 1'b1) break;
    end
    check("w8_latency", 64'(cyc), 64'(WN + 2));
    bn.start = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bw.start = 1'b0; bw.op = '0; bw.a = '0; bw.b = '0; bw.cancel = 1'b0;
    bn.start = 1'b0; bn.op = '0; bn.a = '0; bn.b = '0; bn.cancel = 1'b0;
    repeat (2) @(negedge clk);
    check("w32_reset_outputs", {60'd0, bw.busy, bw.done, bw.stall, 1'b0}, 64'd0);
    check("w32_reset_hilo", {bw.hi, bw.lo}, 64'd0);
    rst_w  = 1'b1;
    rst_n8 = 1'b1;
    @(negedge clk);

    run_w(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_w(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002);
    run_w(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    run_w(OP_DIVU,  32'h0000_0005, 32'h0000_0000);
    run_w(OP_DIV,   32'hFFFF_FFFB, 32'h0000_0000);
    run_w(OP_MULT,  32'h8000_0000, 32'hFFFF_FFFF);
    run_w(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007);

    // Cancel mid-operation: hi/lo must survive untouched.
    run_w(OP_DIVU, 32'h0ACF_1234, 32'h0000_2000);
    bw.op = OP_MULT; bw.a = $urandom; bw.b = $urandom; bw.start = 1'b1;
    repeat (10) @(negedge clk);
    bw.cancel = 1'b1;
    bw.start = 1'b0;
    @(negedge clk);
    check("cancel_busy", {63'd0, bw.busy}, 64'd0);
    check("cancel_hilo_hold", {bw.hi, bw.lo}, 64'h0000_1234_0000_5678);
    bw.cancel = 1'b0;
    run_w(OP_DIVU, 32'd100, 32'd7);

    // Start coinciding with cancel must be dropped.
    bw.op = OP_MULTU; bw.a = 32'd3; bw.b = 32'd3; bw.start = 1'b1; bw.cancel = 1'b1;
    @(negedge clk);
    check("cancel_blocks_start", {63'd0, bw.busy}, 64'd0);
    bw.start = 1'b0; bw.cancel = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      run_w(2'($urandom_range(0, 3)), pick32(), pick32());
    end

    run_n(OP_MULT, 8'hFD, 8'h05);

    // Asynchronous reset mid-operation.
    bn.op = OP_MULT; bn.a = 8'hFD; bn.b = 8'h05; bn.start = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    rst_n8 = 1'b0;
    bn.start = 1'b0;
    #1;
    check("w8_async_reset", {44'd0, bn.busy, bn.done, bn.stall, 1'b0, bn.hi, bn.lo}, 64'd0);
    @(negedge clk);
    rst_n8 = 1'b1;
    repeat (15) @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_n(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    repeat (3) @(negedge clk);
    check("w32_scoreboard_drained", 64'(exp_w.size()), 64'd0);
    check("w8_scoreboard_drained", 64'(exp_n.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
